mio_bridge: RTL and testbench



---
 rtl/mio_pkg.sv | 51 +++++
 rtl/mio_lane_align.sv | 46 ++++
 rtl/mio_bridge.sv | 189 ++++++++++++++++++
 tb/tb_mio_bridge.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared types and helpers for the CPU memory-interface bridge.
package mio_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned BE_W    = 4;
    localparam int unsigned WCNT_W  = 4;
    localparam int unsigned STATE_W = 3;

    // Bridge FSM state encoding
    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_WAIT    = 3'd1;
    localparam logic [STATE_W-1:0] S_ACCESS  = 3'd2;
    localparam logic [STATE_W-1:0] S_CAPTURE = 3'd3;
    localparam logic [STATE_W-1:0] S_DONE    = 3'd4;

    // Access size codes as driven by the CPU (2'b10 behaves as a word)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    // Captured request attributes (address is held separately, its width is a parameter)
    typedef struct packed {
        logic              store;
        logic [1:0]        size;
        logic              sign;
        logic [DATA_W-1:0] data;
    } mio_req_t;

    // Byte-lane enables for a given size and byte offset within the word
    function automatic logic [BE_W-1:0] be_lookup(input logic [1:0] size, input logic [1:0] off);
        logic [BE_W-1:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    // True when the offset does not match the natural alignment of the size
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = (off != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mio_lane_align.sv
// Byte-lane steering: enables, store replication and load extract/extend.
module mio_lane_align
    import mio_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        off,
    input  logic              load_signed,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rdata,
    output logic [BE_W-1:0]   be_c,
    output logic [DATA_W-1:0] wdata_c,
    output logic [DATA_W-1:0] rdata_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: lane enables and replicated write data
    always_comb begin
        be_c    = be_lookup(size, off);
        wdata_c = wdata;
        case (size)
            SZ_BYTE: wdata_c = {4{wdata[7:0]}};
            SZ_HALF: wdata_c = {2{wdata[15:0]}};
            default: wdata_c = wdata;
        endcase
    end

    // Load side: pick addressed lane(s), right-align, then extend
    always_comb begin
        byte_sel = rdata[7:0];
        case (off)
            2'd0: byte_sel = rdata[7:0];
            2'd1: byte_sel = rdata[15:8];
            2'd2: byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = off[1] ? rdata[31:16] : rdata[15:0];
        case (size)
            SZ_BYTE: rdata_c = {{24{load_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: rdata_c = {{16{load_signed & half_sel[15]}}, half_sel};
            default: rdata_c = rdata;
        endcase
    end

endmodule

// File: rtl/mio_bridge.sv
// CPU-to-Memory bridge: one access at a time, programmable wait states,
// MIO_ready handshake. Optional alignment trap under MIO_ALIGN_CHECK_EN.
module mio_bridge
    import mio_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 32
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [ADDR_W-1:0] Addr_out,
    input  logic [DATA_W-1:0] Data_out,
    input  logic [1:0]        StoreX,
    input  logic              load_signed,
    output logic [DATA_W-1:0] Data_in,
    output logic              MIO_ready,
    output logic              align_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [WCNT_W-1:0] WAIT_LAST = (WAIT_CYCLES == 0) ? '0 : WCNT_W'(WAIT_CYCLES - 1);
    localparam logic              WAIT_EN   = (WAIT_CYCLES != 0);

    logic [STATE_W-1:0] state_q, state_d;
    logic [WCNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    mio_req_t           req_q, req_d;
    logic               err_q, err_d;
    logic [DATA_W-1:0]  rcap_q, rcap_d;

    logic               take_c;
    logic               misalign_c;
    logic [BE_W-1:0]    be_c;
    logic [DATA_W-1:0]  wdata_c;
    logic [DATA_W-1:0]  rdata_c;

    logic [DATA_W-1:0]  data_in_d;
    logic               ready_d;
    logic               align_err_d;
    logic [ADDR_W-1:0]  mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_d;
    logic [BE_W-1:0]    mem_be_d;
    logic               mem_re_d;
    logic               mem_we_d;
    logic               enter_access;

`ifdef MIO_ALIGN_CHECK_EN
    assign misalign_c = is_misaligned(StoreX, Addr_out[1:0]);
`else
    assign misalign_c = 1'b0;
`endif

    // Request capture: CPU inputs are only looked at while idle
    always_comb begin
        take_c = (state_q == S_IDLE) && CPU_MIO;
        addr_d = addr_q;
        req_d  = req_q;
        if (take_c) begin
            addr_d     = Addr_out;
            req_d.store = mem_w;
            req_d.size  = StoreX;
            req_d.sign  = load_signed;
            req_d.data  = Data_out;
        end
    end

    // Lane steering works on the request as it will be held next cycle
    mio_lane_align u_lane (
        .size        (req_d.size),
        .off         (addr_d[1:0]),
        .load_signed (req_d.sign),
        .wdata       (req_d.data),
        .rdata       (mem_rdata),
        .be_c        (be_c),
        .wdata_c     (wdata_c),
        .rdata_c     (rdata_c)
    );

    // Next-state and registered-output values
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        rcap_d       = rcap_q;
        data_in_d    = Data_in;
        ready_d      = 1'b0;
        align_err_d  = 1'b0;
        mem_addr_d   = '0;
        mem_wdata_d  = '0;
        mem_be_d     = '0;
        mem_re_d     = 1'b0;
        mem_we_d     = 1'b0;
        enter_access = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (take_c) begin
                    cnt_d = '0;
                    err_d = misalign_c;
                    if (misalign_c) begin
                        state_d = S_DONE;
                    end else if (WAIT_EN) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d      = S_ACCESS;
                        enter_access = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    state_d      = S_ACCESS;
                    enter_access = 1'b1;
                end else begin
                    cnt_d = cnt_q + WCNT_W'(1);
                end
            end
            S_ACCESS: begin
                state_d = req_q.store ? S_DONE : S_CAPTURE;
            end
            S_CAPTURE: begin
                rcap_d  = rdata_c;
                state_d = S_DONE;
            end
            S_DONE: begin
                ready_d     = 1'b1;
                align_err_d = err_q;
                if (err_q) begin
                    data_in_d = '0;
                end else if (!req_q.store) begin
                    data_in_d = rcap_q;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        if (enter_access) begin
            mem_addr_d  = {addr_d[ADDR_W-1:2], 2'b00};
            mem_be_d    = be_c;
            mem_wdata_d = wdata_c;
            mem_re_d    = ~req_d.store;
            mem_we_d    = req_d.store;
        end
    end

    // State, capture registers and outputs; reset aborts any access in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            req_q     <= '0;
            err_q     <= 1'b0;
            rcap_q    <= '0;
            Data_in   <= '0;
            MIO_ready <= 1'b0;
            align_err <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            mem_re    <= 1'b0;
            mem_we    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            err_q     <= err_d;
            rcap_q    <= rcap_d;
            Data_in   <= data_in_d;
            MIO_ready <= ready_d;
            align_err <= align_err_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            mem_be    <= mem_be_d;
            mem_re    <= mem_re_d;
            mem_we    <= mem_we_d;
        end
    end

endmodule

// File: tb/tb_mio_bridge.sv
// Bench for mio_bridge: byte-addressed reference memory plus a per-cycle
// expectation of strobes, ready and Data_in. Honours MIO_ALIGN_CHECK_EN.
module tb_mio_bridge;

    localparam int unsigned W  = 2;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          CPU_MIO = 1'b0;
    logic          mem_w = 1'b0;
    logic [AW-1:0] Addr_out = '0;
    logic [31:0]   Data_out = '0;
    logic [1:0]    StoreX = 2'b00;
    logic          load_signed = 1'b0;
    logic [31:0]   Data_in;
    logic          MIO_ready;
    logic          align_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_be;
    logic          mem_re;
    logic          mem_we;
    logic [31:0]   mem_rdata = '0;

    always #5 clk = ~clk;

    mio_bridge #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .CPU_MIO(CPU_MIO), .mem_w(mem_w),
        .Addr_out(Addr_out), .Data_out(Data_out), .StoreX(StoreX),
        .load_signed(load_signed), .Data_in(Data_in), .MIO_ready(MIO_ready),
        .align_err(align_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_re(mem_re), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Synchronous memory seen by the DUT
    logic [31:0] ram [0:63];
    logic [31:0] wr_merge;
    always @(posedge clk) begin
        if (mem_we) begin
            wr_merge = ram[mem_addr[7:2]];
            for (int b = 0; b < 4; b++)
                if (mem_be[b]) wr_merge[8*b +: 8] = mem_wdata[8*b +: 8];
            ram[mem_addr[7:2]] = wr_merge;
        end
        if (mem_re) mem_rdata <= ram[mem_addr[7:2]];
    end

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errs   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: byte memory plus the single outstanding transaction
    logic [7:0]  gm [0:255];
    bit          m_active = 1'b0;
    bit          m_store, m_err;
    int unsigned m_cap, m_strobe, m_ready;
    int          m_len;
    logic [7:0]  m_base;
    logic [31:0] m_addr_w, m_wdata, m_load, m_data;
    logic [3:0]  m_be;
    logic [31:0] m_held = '0;

    function automatic logic [31:0] model_load(input logic [7:0] base, input int len, input bit sg);
        logic [31:0] v = '0;
        for (int i = 0; i < len; i++) v[8*i +: 8] = gm[int'(base) + i];
        if (sg && len < 4 && v[8*len-1])
            for (int i = len; i < 4; i++) v[8*i +: 8] = 8'hFF;
        return v;
    endfunction

    task automatic model_store(input logic [7:0] base, input int len, input logic [31:0] d);
        for (int i = 0; i < len; i++) gm[int'(base) + i] = d[8*i +: 8];
    endtask

    // Per-cycle comparison against the model
    bit hit_s, hit_r;
    always @(negedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_held   = '0;
        end
        hit_s = m_active && !m_err && (cyc == m_strobe);
        hit_r = m_active && (cyc == m_ready);
        if (hit_r && (m_err || !m_store)) m_held = m_err ? 32'h0 : m_load;
        chk("mem_re",    32'(mem_re),    32'(hit_s && !m_store));
        chk("mem_we",    32'(mem_we),    32'(hit_s && m_store));
        chk("mem_be",    32'(mem_be),    hit_s ? 32'(m_be) : 32'h0);
        chk("mem_wdata", mem_wdata,      hit_s ? m_wdata : 32'h0);
        if (hit_s) chk("mem_addr", mem_addr, m_addr_w);
        chk("MIO_ready", 32'(MIO_ready), 32'(hit_r));
        chk("align_err", 32'(align_err), 32'(hit_r && m_err));
        chk("Data_in",   Data_in,        m_held);
    end

    // Observation of events, used for literal latency/lane checks
    int unsigned we_cyc, re_cyc, rdy_cyc;
    int we_cnt = 0, re_cnt = 0, rdy_cnt = 0, aerr_cnt = 0;
    logic [3:0]  mon_be;
    logic [31:0] mon_wd;
    always @(negedge clk) begin
        if (mem_we) begin we_cnt++; we_cyc = cyc; mon_be = mem_be; mon_wd = mem_wdata; end
        if (mem_re) begin re_cnt++; re_cyc = cyc; end
        if (MIO_ready) begin rdy_cnt++; rdy_cyc = cyc; end
        if (align_err) aerr_cnt++;
    end

    task automatic start_txn(input bit st, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz, input bit sg);
        bit mis;
        CPU_MIO = 1'b1; mem_w = st; Addr_out = a; Data_out = d; StoreX = sz; load_signed = sg;
        m_len = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
`ifdef MIO_ALIGN_CHECK_EN
        mis = (m_len == 2 && a[0]) || (m_len == 4 && a[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        m_base   = a[7:0] & ~8'(m_len - 1);
        m_cap    = cyc + 1;
        m_store  = st;
        m_err    = mis;
        m_data   = d;
        m_strobe = m_cap + W;
        m_ready  = mis ? m_cap + 1 : m_cap + W + (st ? 2 : 3);
        m_addr_w = a & ~32'h3;
        for (int n = 0; n < 4; n++) begin
            m_be[n] = (n >= int'(m_base[1:0])) && (n < int'(m_base[1:0]) + m_len);
            m_wdata[8*n +: 8] = d[8*(n % m_len) +: 8];
        end
        m_load   = model_load(m_base, m_len, sg);
        m_active = 1'b1;
    endtask

    task automatic run(input bit st, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz, input bit sg, input bit hold);
        start_txn(st, a, d, sz, sg);
        @(negedge clk); #1;
        if (!hold) begin
            CPU_MIO = 1'b0; Addr_out = ~a; Data_out = ~d; StoreX = ~sz;
            mem_w = ~st; load_signed = ~sg;
        end
        while (cyc < m_ready) begin @(negedge clk); #1; end
        if (st && !m_err) model_store(m_base, m_len, m_data);
        if (!hold) begin @(negedge clk); #1; end
    endtask

    int unsigned r1;
    int we0, rdy0, re0, bad;
    logic [31:0] word;

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = {8'(i), 8'hA0, 8'(i * 3), 8'h5C};
        ram[8]  = 32'h80FF7F01;
        ram[12] = 32'h0BADF00D;
        for (int i = 0; i < 64; i++)
            for (int b = 0; b < 4; b++) gm[4*i + b] = ram[i][8*b +: 8];

        repeat (3) @(negedge clk);
        #1;
        chk("rst_Data_in", Data_in, 32'h0);
        chk("rst_ready", 32'(MIO_ready), 32'h0);
        chk("rst_we", 32'(mem_we), 32'h0);
        reset = 1'b0;
        @(negedge clk); #1;

        // Word store: strobe two cycles after capture, ready two later
        run(1'b1, 32'h10, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0);
        chk("st_word_we_lat", we_cyc - m_cap, 32'd2);
        chk("st_word_rdy_lat", rdy_cyc - m_cap, 32'd4);
        chk("st_word_be", 32'(mon_be), 32'hF);
        chk("st_word_wd", mon_wd, 32'hDEADBEEF);

        // Byte store into lane 3
        run(1'b1, 32'h13, 32'h000000A5, 2'b00, 1'b0, 1'b0);
        chk("st_byte_be", 32'(mon_be), 32'h8);
        chk("st_byte_wd", mon_wd, 32'hA5A5A5A5);

        run(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 1'b0);
        chk("ld_word_merge", Data_in, 32'hA5ADBEEF);
        chk("ld_word_rdy_lat", rdy_cyc - m_cap, 32'd5);
        chk("ld_word_re_lat", re_cyc - m_cap, 32'd2);

        // Sub-word loads from 0x80FF7F01
        run(1'b0, 32'h22, 32'h0, 2'b00, 1'b1, 1'b0);
        chk("ld_byte_s", Data_in, 32'hFFFFFFFF);
        run(1'b0, 32'h22, 32'h0, 2'b00, 1'b0, 1'b0);
        chk("ld_byte_u", Data_in, 32'h000000FF);
        run(1'b0, 32'h22, 32'h0, 2'b01, 1'b1, 1'b0);
        chk("ld_half_s", Data_in, 32'hFFFF80FF);
        run(1'b0, 32'h20, 32'h0, 2'b01, 1'b1, 1'b0);
        chk("ld_half_lo_s", Data_in, 32'h00007F01);

        // Half store to upper lanes, size 10 behaves as word
        run(1'b1, 32'h26, 32'hCAFE1234, 2'b01, 1'b0, 1'b0);
        chk("st_half_be", 32'(mon_be), 32'hC);
        chk("st_half_wd", mon_wd, 32'h12341234);
        run(1'b0, 32'h24, 32'h0, 2'b10, 1'b0, 1'b0);

        // Back-to-back with CPU_MIO held high
        run(1'b0, 32'h20, 32'h0, 2'b11, 1'b0, 1'b1);
        r1 = rdy_cyc;
        run(1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 1'b1);
        chk("b2b_gap", re_cyc - r1, 32'd3);
        chk("b2b_data", Data_in, 32'hA5ADBEEF);
        CPU_MIO = 1'b0;
        @(negedge clk); #1;

        // Reset during WAIT of a store aborts it
        we0 = we_cnt; rdy0 = rdy_cnt;
        start_txn(1'b1, 32'h30, 32'h12345678, 2'b11, 1'b0);
        @(negedge clk); #1;
        CPU_MIO = 1'b0; reset = 1'b1;
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (8) begin @(negedge clk); #1; end
        chk("abort_no_we", 32'(we_cnt - we0), 32'h0);
        chk("abort_no_ready", 32'(rdy_cnt - rdy0), 32'h0);
        chk("abort_mem", ram[12], 32'h0BADF00D);
        chk("abort_Data_in", Data_in, 32'h0);

        // Misaligned word load
        re0 = re_cnt;
        run(1'b0, 32'h21, 32'h0, 2'b11, 1'b0, 1'b0);
`ifdef MIO_ALIGN_CHECK_EN
        chk("mis_rdy_lat", rdy_cyc - m_cap, 32'd1);
        chk("mis_Data_in", Data_in, 32'h0);
        chk("mis_no_re", 32'(re_cnt - re0), 32'h0);
        chk("mis_aerr", 32'(aerr_cnt), 32'h1);
`else
        chk("mis_rdy_lat", rdy_cyc - m_cap, 32'd5);
        chk("mis_Data_in", Data_in, 32'h80FF7F01);
        chk("mis_aerr", 32'(aerr_cnt), 32'h0);
`endif

        // Whole-memory agreement with the reference
        bad = 0;
        for (int i = 0; i < 64; i++) begin
            for (int b = 0; b < 4; b++) word[8*b +: 8] = gm[4*i + b];
            if (ram[i] !== word) bad++;
        end
        chk("ram_sweep", 32'(bad), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, errors=%0d", n_errs);
        $fatal(1);
    end

endmodule
